// File: rtl/aes_inv_key_sched_pkg.sv
// aes_inv_key_sched_pkg: shared AES constants, FSM encoding, Rcon table and GF(2^8) multiply.
package aes_inv_key_sched_pkg;
  localparam logic [3:0] NR = 4'd10;
  typedef enum logic [1:0] {IDLE, EXPAND, PRESENT} state_t;
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
endpackage

// File: rtl/aes_inv_key_sched_sbox.sv
// aes_inv_key_sched_sbox: combinational AES S-box; a = input byte, y = substituted byte.
module aes_inv_key_sched_sbox
  import aes_inv_key_sched_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, v;
  // Multiplicative inverse as a^254 (0 maps to 0), then the affine map.
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    v    = gmul(x252, x2);
    y    = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: AES-128 key schedule that expands forward once, then walks round keys 10..0.
//   clk, rst_n (sync active-low), key_load/key_in start expansion, next accepts rk_out;
//   busy during expansion, rk_valid/rk_out/rk_round present keys, done pulses after round 0.
module aes_inv_key_sched
  import aes_inv_key_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         next,
  output logic         busy,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);
  state_t state, state_n;
  logic [127:0] key;
  logic [3:0] cnt, rnd;
  logic [31:0] w0, w1, w2, w3, sin, rot, sub, t0, e1, e2, e3;
  logic last, fin;
  assign {w0, w1, w2, w3} = key;
  // One S-box row serves both directions: backward steps need SubWord of the recovered w3.
  assign sin = state == PRESENT ? w3 ^ w2 : w3;
  assign rot = {sin[23:0], sin[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_inv_key_sched_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end
  // New w0 forward and recovered w0 backward share the same w0 ^ SubWord ^ Rcon form.
  assign t0 = w0 ^ sub ^ {rcon(state == PRESENT ? rnd - 4'd1 : cnt), 24'h0};
  assign e1 = t0 ^ w1;
  assign e2 = e1 ^ w2;
  assign e3 = e2 ^ w3;
  assign last = cnt == NR - 4'd1;
  assign fin = state == PRESENT && next && rnd == 4'd0;
  always_comb begin
    state_n = state;
    if (key_load) state_n = EXPAND;
    else if (state == EXPAND && last) state_n = PRESENT;
    else if (fin) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      key   <= '0;
      cnt   <= '0;
      rnd   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= fin && !key_load;
      if (key_load) begin
        key <= key_in;
        cnt <= '0;
        rnd <= '0;
      end else if (state == EXPAND) begin
        key <= {t0, e1, e2, e3};
        cnt <= cnt + 4'd1;
        if (last) rnd <= NR;
      end else if (state == PRESENT && next && rnd != 4'd0) begin
        key <= {t0, w1 ^ w0, w2 ^ w1, w3 ^ w2};
        rnd <= rnd - 4'd1;
      end
    end
  end
  assign busy = state == EXPAND;
  assign rk_valid = state == PRESENT;
  assign rk_out = key;
  assign rk_round = rnd;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: directed scoreboard bench for aes_inv_key_sched.
module tb_aes_inv_key_sched;
  logic clk = 1'b0;
  logic rst_n, key_load, next;
  logic [127:0] key_in;
  logic busy, rk_valid, done;
  logic [127:0] rk_out;
  logic [3:0] rk_round;
  typedef struct {
    logic [3:0]   r;
    logic [127:0] k;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int passed = 0;
  int failed = 0;
  logic [127:0] ka [0:10];
  logic [127:0] kb, kb10;
  aes_inv_key_sched dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .next(next),
    .busy(busy), .rk_valid(rk_valid), .rk_out(rk_out), .rk_round(rk_round), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pop_chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 128'd1, 128'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_valid"}, {127'd0, rk_valid}, 128'd1);
      chk({tag, "_round"}, {124'd0, rk_round}, {124'd0, e.r});
      chk({tag, "_key"}, rk_out, e.k);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
    ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kb     = 128'h000102030405060708090a0b0c0d0e0f;
    kb10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    rst_n = 1'b0; key_load = 1'b0; next = 1'b0; key_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_round", {124'd0, rk_round}, 128'd0);
    chk("rst_key", rk_out, 128'd0);
    rst_n = 1'b1;
    key_in = ka[0]; key_load = 1'b1;
    for (int r = 10; r >= 0; r--) q.push_back('{r: 4'(r), k: ka[r]});
    @(negedge clk);
    key_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("expand_busy", {127'd0, busy}, 128'd1);
      chk("expand_valid", {127'd0, rk_valid}, 128'd0);
      @(negedge clk);
    end
    chk("present_busy", {127'd0, busy}, 128'd0);
    pop_chk("r10");
    for (int r = 9; r >= 0; r--) begin
      if (r == 5) begin
        repeat (5) begin
          @(negedge clk);
          chk("hold_round", {124'd0, rk_round}, 128'd6);
          chk("hold_key", rk_out, ka[6]);
        end
      end
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      chk("step_done", {127'd0, done}, 128'd0);
      pop_chk("step");
    end
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("fin_done", {127'd0, done}, 128'd1);
    chk("fin_valid", {127'd0, rk_valid}, 128'd0);
    chk("fin_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    chk("fin_done_once", {127'd0, done}, 128'd0);
    repeat (3) begin
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      chk("idle_done", {127'd0, done}, 128'd0);
      chk("idle_valid", {127'd0, rk_valid}, 128'd0);
      chk("idle_round", {124'd0, rk_round}, 128'd0);
      chk("idle_key", rk_out, ka[0]);
    end
    key_in = ka[0]; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("restart_busy", {127'd0, busy}, 128'd1);
    key_in = kb; key_load = 1'b1;
    q.delete();
    q.push_back('{r: 4'd10, k: kb10});
    @(negedge clk);
    key_load = 1'b0;
    n = 0;
    while (!rk_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("restart_latency", 128'(n), 128'd10);
    pop_chk("restart_r10");
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("b_r9_round", {124'd0, rk_round}, 128'd9);
    rst_n = 1'b0; next = 1'b1; key_load = 1'b1; key_in = ka[0];
    @(negedge clk);
    rst_n = 1'b1; next = 1'b0; key_load = 1'b0;
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_valid", {127'd0, rk_valid}, 128'd0);
    chk("abort_done", {127'd0, done}, 128'd0);
    chk("abort_round", {124'd0, rk_round}, 128'd0);
    chk("abort_key", rk_out, 128'd0);
    @(negedge clk);
    chk("abort_no_done", {127'd0, done}, 128'd0);
    chk("abort_idle", {126'd0, busy, rk_valid}, 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
